// File: rtl/cfc_pkg.sv
// Shared constants and types for the branch checkpoint store (CFC) and its
// neighbours: the free register list (FRL), dispatch and the ROB.
//   CFC_DEPTH      number of checkpoint slots (max in-flight branches)
//   CFC_TAG_WIDTH  width of a branch tag (= slot index)
//   FRL_PTR_WIDTH  width of the FRL head pointer, wrap bit included
package cfc_pkg;

  localparam int CFC_DEPTH     = 8;
  localparam int CFC_TAG_WIDTH = 3;
  localparam int FRL_PTR_WIDTH = 5;

  typedef logic [CFC_TAG_WIDTH-1:0] cfc_tag_t;
  typedef logic [FRL_PTR_WIDTH-1:0] frl_ptr_t;

endpackage

// File: rtl/frl_checkpoint_ctrl.sv
// Branch checkpoint store for the FRL head pointer.
// A dispatched branch snapshots Frl_HeadPtr into a circular queue and gets the
// slot index as its tag. A misprediction reads the saved pointer for its tag
// combinationally and drops every younger checkpoint; a branch commit retires
// the oldest checkpoint.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   Frl_HeadPtr         FRL head pointer sampled at branch dispatch
//   Dis_BranchDispatch  take a checkpoint this cycle
//   Cfc_BranchTag       tag given to the dispatching branch (tail slot)
//   Cfc_Full/Cfc_Empty  queue occupancy flags
//   Rob_CommitBranch    retire the oldest checkpoint
//   Cdb_Flush           misprediction of branch Cdb_BranchTag
//   Cdb_BranchTag       tag being flushed / read
//   Cfc_FrlHeadPtr      saved FRL head for Cdb_BranchTag (zero latency)
//   Cfc_Err             sticky protocol-error flag
module frl_checkpoint_ctrl
  import cfc_pkg::*;
#(
  parameter int PTR_WIDTH = FRL_PTR_WIDTH,
  parameter int DEPTH     = CFC_DEPTH,
  parameter int TAG_WIDTH = CFC_TAG_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PTR_WIDTH-1:0] Frl_HeadPtr,
  input  logic                 Dis_BranchDispatch,
  output logic [TAG_WIDTH-1:0] Cfc_BranchTag,
  output logic                 Cfc_Full,
  output logic                 Cfc_Empty,
  input  logic                 Rob_CommitBranch,
  input  logic                 Cdb_Flush,
  input  logic [TAG_WIDTH-1:0] Cdb_BranchTag,
  output logic [PTR_WIDTH-1:0] Cfc_FrlHeadPtr,
  output logic                 Cfc_Err
);

  localparam logic [TAG_WIDTH:0] LP_QONE = {{TAG_WIDTH{1'b0}}, 1'b1};

  logic [PTR_WIDTH-1:0] r_ckpt [DEPTH];
  logic [TAG_WIDTH:0]   r_head;
  logic [TAG_WIDTH:0]   r_tail;
  logic                 r_err;

  logic [TAG_WIDTH:0]   w_count;
  logic                 w_full;
  logic                 w_empty;
  logic [TAG_WIDTH-1:0] w_tail_idx;
  logic [TAG_WIDTH-1:0] w_off;
  logic                 w_tag_live;
  logic                 w_flush_ok;
  logic                 w_dispatch;
  logic                 w_commit;
  logic                 w_err_set;
  logic [TAG_WIDTH:0]   w_tail_next;
  logic [DEPTH-1:0]     w_slot_we;

  assign w_count    = r_tail - r_head;
  // Count never exceeds DEPTH, so its top bit alone marks a full queue.
  assign w_full     = w_count[TAG_WIDTH];
  assign w_empty    = (w_count == '0);
  assign w_tail_idx = r_tail[TAG_WIDTH-1:0];

  // Distance of the flushed tag from the oldest live slot; beyond Count the
  // tag does not belong to a live branch.
  assign w_off      = Cdb_BranchTag - r_head[TAG_WIDTH-1:0];
  assign w_tag_live = ({1'b0, w_off} < w_count);
  assign w_flush_ok = Cdb_Flush && w_tag_live;

  // A flush squashes any same-cycle dispatch: that branch is younger.
  assign w_dispatch = Dis_BranchDispatch && !w_full && !Cdb_Flush;
  assign w_commit   = Rob_CommitBranch && !w_empty;

  assign w_err_set  = (Dis_BranchDispatch && w_full)
                   || (Rob_CommitBranch && w_empty)
                   || (Cdb_Flush && !w_tag_live);

  always_comb begin
    w_tail_next = r_tail;
    if (w_flush_ok) begin
      // Offset is taken from the pre-commit head even when a commit lands in
      // the same cycle.
      w_tail_next = r_head + {1'b0, w_off} + LP_QONE;
    end else if (w_dispatch) begin
      w_tail_next = r_tail + LP_QONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head <= '0;
      r_tail <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_commit) begin
        r_head <= r_head + LP_QONE;
      end
      r_tail <= w_tail_next;
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  // One write port per slot, selected by the tail index.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign w_slot_we[gi] = w_dispatch && (w_tail_idx == TAG_WIDTH'(gi));

      always_ff @(posedge clk) begin
        if (reset) begin
          r_ckpt[gi] <= '0;
        end else if (w_slot_we[gi]) begin
          r_ckpt[gi] <= Frl_HeadPtr;
        end
      end
    end
  endgenerate

  assign Cfc_BranchTag  = w_tail_idx;
  assign Cfc_Full       = w_full;
  assign Cfc_Empty      = w_empty;
  assign Cfc_FrlHeadPtr = r_ckpt[Cdb_BranchTag];
  assign Cfc_Err        = r_err;

endmodule
